// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM word controller and its beat timer.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int beats_f(input int word_w, input int sram_dw);
    return word_w / sram_dw;
  endfunction

  function automatic int offset_shift_f(input int word_w);
    return $clog2(word_w / 32'sd8);
  endfunction

  // A counter always needs at least one bit, even when it only ever holds 0.
  function automatic int cnt_w_f(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat sequencing for one multi-beat SRAM access; both counters
// sit at zero whenever run is low.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int BEATS       = 2,
  parameter int WAIT_CW     = cnt_w_f(WAIT_CYCLES),
  parameter int BEAT_CW     = cnt_w_f(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [BEAT_CW-1:0] beat_idx,
  output logic               last_wait,
  output logic               last_beat
);

  logic [WAIT_CW-1:0] wait_q, wait_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;

  assign last_wait = (wait_q == WAIT_CW'(WAIT_CYCLES - 32'sd1));
  assign last_beat = (beat_q == BEAT_CW'(BEATS - 32'sd1));
  assign beat_idx  = beat_q;

  // Next counter values: wait counter wraps per beat, beat counter wraps per access.
  always_comb begin
    wait_d = wait_q;
    beat_d = beat_q;
    if (!run) begin
      wait_d = '0;
      beat_d = '0;
    end else if (last_wait) begin
      wait_d = '0;
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      wait_q <= wait_d;
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// Splits one pipeline word access into sequential SRAM beats and freezes the
// pipeline through ready until the whole word has been transferred.
module sram_word_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          WORD_W      = 32,
  parameter int          SRAM_DW     = 16,
  parameter int          SRAM_AW     = 18,
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = 32'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [WORD_W-1:0]     write_data,
  input  logic [WORD_W/8-1:0]   byte_en,
  output logic [WORD_W-1:0]     read_data,
  output logic                  ready,
  inout  wire  [SRAM_DW-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0]    SRAM_ADDR,
  output logic [SRAM_DW/8-1:0]  SRAM_BE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N
);

  localparam int BEATS   = beats_f(WORD_W, SRAM_DW);
  localparam int SHIFT   = offset_shift_f(WORD_W);
  localparam int BEAT_CW = cnt_w_f(BEATS);
  localparam int LANES   = SRAM_DW / 8;

  state_e                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [SRAM_AW-1:0]    base_q, base_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [WORD_W/8-1:0]   mask_q, mask_d;
  logic [WORD_W-1:0]     rdata_q, rdata_d;

  logic                  req_s;
  logic [ADDR_W-1:0]     offset_s;
  logic [ADDR_W-1:0]     word_idx_s;
  logic [BEAT_CW-1:0]    beat_idx_s;
  logic                  last_wait_s;
  logic                  last_beat_s;
  logic [SRAM_DW-1:0]    wr_slice_s;
  logic [LANES-1:0]      be_slice_s;
  logic                  dq_oe_s;

  assign req_s      = rd_en | wr_en;
  // Addresses below the base wrap through the subtraction; no error is raised.
  assign offset_s   = address - ADDR_W'(BASE_ADDR);
  assign word_idx_s = offset_s >> SHIFT;
  assign wr_slice_s = wdata_q[beat_idx_s*SRAM_DW +: SRAM_DW];
  assign be_slice_s = mask_q[beat_idx_s*LANES +: LANES];

  sram_beat_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEATS       (BEATS),
    .BEAT_CW     (BEAT_CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state_q == ACCESS),
    .beat_idx  (beat_idx_s),
    .last_wait (last_wait_s),
    .last_beat (last_beat_s)
  );

  // Request latching, read-slice capture and state sequencing.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = ACCESS;
          op_wr_d = wr_en;
          base_d  = SRAM_AW'(word_idx_s * ADDR_W'(BEATS));
          wdata_d = write_data;
          mask_d  = byte_en;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (last_wait_s && !op_wr_q) begin
          rdata_d[beat_idx_s*SRAM_DW +: SRAM_DW] = SRAM_DQ;
        end else begin
          rdata_d = rdata_q;
        end
        if (last_wait_s && last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = ACCESS;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM strobes and pipeline handshake decoded from the current state.
  always_comb begin
    ready     = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_BE_N = '1;
    dq_oe_s   = 1'b0;
    case (state_q)
      IDLE: ready = ~req_s;
      ACCESS: begin
        ready     = 1'b0;
        SRAM_CE_N = 1'b0;
        if (op_wr_q) begin
          SRAM_OE_N = 1'b1;
          SRAM_BE_N = ~be_slice_s;
          dq_oe_s   = 1'b1;
          // WE_N rises on the final wait cycle to give data hold time.
          SRAM_WE_N = (WAIT_CYCLES == 32'sd1) ? 1'b0 : last_wait_s;
        end else begin
          SRAM_OE_N = 1'b0;
          SRAM_BE_N = '0;
          SRAM_WE_N = 1'b1;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  assign SRAM_ADDR = base_q + SRAM_AW'(beat_idx_s);
  assign SRAM_DQ   = dq_oe_s ? wr_slice_s : {SRAM_DW{1'bz}};
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Self-checking bench: directed cases plus randomized accesses against a
// per-cycle behavioural model of the SRAM word controller.
module tb_sram_word_ctrl;

  localparam int W   = 3;
  localparam int B   = 2;
  localparam int LAT = B * W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = 32'd0, write_data = 32'd0;
  logic [3:0]  byte_en = 4'd0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic [1:0]  sram_be_n;
  logic        we_n, ce_n, oe_n;

  logic        wr_w = 1'b0, rd_w = 1'b0;
  logic [31:0] addr_w = 32'd0;
  logic [63:0] wd_w = 64'd0;
  logic [7:0]  be_w = 8'd0;
  logic [63:0] rdata_w;
  logic        ready_w;
  wire  [15:0] dq_w;
  logic [17:0] sram_addr_w;
  logic [1:0]  be_n_w;
  logic        we_n_w, ce_n_w, oe_n_w;

  logic [15:0] bus_mem   [1024];
  logic [15:0] model_mem [1024];
  logic [31:0] model_rdata = 32'd0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_word_ctrl u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .byte_en(byte_en), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_BE_N(sram_be_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_word_ctrl #(
    .WORD_W(64), .SRAM_DW(16), .SRAM_AW(18), .ADDR_W(32), .WAIT_CYCLES(1), .BASE_ADDR(1024)
  ) u_dut64 (
    .clk(clk), .rst(rst), .wr_en(wr_w), .rd_en(rd_w), .address(addr_w),
    .write_data(wd_w), .byte_en(be_w), .read_data(rdata_w), .ready(ready_w),
    .SRAM_DQ(dq_w), .SRAM_ADDR(sram_addr_w), .SRAM_BE_N(be_n_w),
    .SRAM_WE_N(we_n_w), .SRAM_CE_N(ce_n_w), .SRAM_OE_N(oe_n_w)
  );

  // SRAM device model: drives data when output-enabled, stores enabled lanes on write.
  assign sram_dq = (!oe_n && !ce_n) ? bus_mem[sram_addr[9:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      for (int l = 0; l < 2; l++) begin
        if (!sram_be_n[l]) bus_mem[sram_addr[9:0]][l*8 +: 8] <= sram_dq[l*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ce_n"}, ce_n, 1);
    chk({name, "_we_n"}, we_n, 1);
    chk({name, "_oe_n"}, oe_n, 1);
    chk({name, "_be_n"}, sram_be_n, 2'b11);
  endtask

  function automatic logic [17:0] exp_addr(input logic [31:0] a, input int beat);
    logic [31:0] wi;
    wi = (a - 32'd1024) >> 2;
    return 18'(wi * 32'd2 + 32'(beat));
  endfunction

  // One full access, compared against the model on every cycle from request to DONE.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output int rdy_at, output int we_low,
                            output logic [1:0] be_b0, output logic [1:0] be_b1);
    logic [31:0] exp_rd;
    logic [17:0] ea;
    logic [1:0]  e_be;
    logic        e_we, e_oe;
    logic [15:0] e_dq;
    int beat, w;
    rdy_at = -1; we_low = 0; be_b0 = 2'b00; be_b1 = 2'b00;
    exp_rd = {model_mem[exp_addr(a, 1)][9:0] == 10'd0 ? model_mem[exp_addr(a, 1)] : model_mem[exp_addr(a, 1)], 16'h0};
    exp_rd = {model_mem[exp_addr(a, 1) & 18'h3FF], model_mem[exp_addr(a, 0) & 18'h3FF]};
    rd_en = rd; wr_en = wr; address = a; write_data = wd; byte_en = be;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (ready === 1'b1 && rdy_at < 0) rdy_at = k;
      if (k == 0) begin
        chk("c0_ready", ready, 0);
        chk("c0_ce_n", ce_n, 1);
        chk("c0_rdata", read_data, model_rdata);
      end else if (k < LAT) begin
        beat = (k - 1) / W;
        w    = (k - 1) % W;
        ea   = exp_addr(a, beat);
        e_oe = wr;
        e_we = wr ? (w == W - 1) : 1'b1;
        e_be = wr ? ~be[beat*2 +: 2] : 2'b00;
        e_dq = wd[beat*16 +: 16];
        chk("acc_ready", ready, 0);
        chk("acc_ce_n", ce_n, 0);
        chk("acc_addr", sram_addr, ea);
        chk("acc_oe_n", oe_n, e_oe);
        chk("acc_we_n", we_n, e_we);
        chk("acc_be_n", sram_be_n, e_be);
        if (wr) begin
          chk("acc_dq", sram_dq, e_dq);
          chk("acc_rdata_hold", read_data, model_rdata);
        end
        if (we_n === 1'b0) we_low++;
        if (w == 0 && beat == 0) be_b0 = sram_be_n;
        if (w == 0 && beat == 1) be_b1 = sram_be_n;
      end else begin
        if (!wr) model_rdata = exp_rd;
        chk("done_ready", ready, 1);
        chk_idle("done");
        chk("done_rdata", read_data, model_rdata);
      end
      @(posedge clk); #1;
      if (k == LAT) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    if (wr) begin
      for (int bt = 0; bt < B; bt++) begin
        for (int l = 0; l < 2; l++) begin
          if (be[bt*2 + l]) model_mem[exp_addr(a, bt) & 18'h3FF][l*8 +: 8] = wd[bt*16 + l*8 +: 8];
        end
      end
    end
  endtask

  // Read interrupted by a synchronous reset during its third cycle.
  task automatic run_reset_read(input logic [31:0] a);
    rd_en = 1'b1; wr_en = 1'b0; address = a;
    for (int k = 0; k <= 4; k++) begin
      if (k == 3) begin
        rst = 1'b1; rd_en = 1'b0;
      end
      @(negedge clk);
      if (k == 0) chk("rr_c0_ready", ready, 0);
      else if (k < 4) begin
        chk("rr_acc_ce_n", ce_n, 0);
        chk("rr_acc_oe_n", oe_n, 0);
      end else begin
        model_rdata = 32'd0;
        chk("rr_ready", ready, 1);
        chk_idle("rr");
        chk("rr_rdata", read_data, 32'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  int rdy_at, we_low;
  logic [1:0] be_b0, be_b1;
  logic [15:0] exp6 [4];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      bus_mem[i] = v;
      model_mem[i] = v;
    end
    bus_mem[2] = 16'hBEEF; model_mem[2] = 16'hBEEF;
    bus_mem[3] = 16'hCAFE; model_mem[3] = 16'hCAFE;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready", ready, 1);
    chk_idle("reset");
    chk("reset_rdata", read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_access(1'b0, 1'b1, 32'd1024, 32'hA5A5_1234, 4'hF, rdy_at, we_low, be_b0, be_b1);
    chk("t1_latency", rdy_at, 7);
    chk("t1_we_low", we_low, 4);
    chk("t1_mem0", bus_mem[0], 16'h1234);
    chk("t1_mem1", bus_mem[1], 16'hA5A5);

    run_access(1'b1, 1'b0, 32'd1028, 32'd0, 4'h0, rdy_at, we_low, be_b0, be_b1);
    chk("t2_latency", rdy_at, 7);
    chk("t2_rdata", read_data, 32'hCAFE_BEEF);
    chk("t2_we_low", we_low, 0);

    run_access(1'b0, 1'b1, 32'd1032, 32'h1122_3344, 4'b0110, rdy_at, we_low, be_b0, be_b1);
    chk("t3_be_b0", be_b0, 2'b01);
    chk("t3_be_b1", be_b1, 2'b10);
    chk("t3_latency", rdy_at, 7);

    run_access(1'b1, 1'b1, 32'd1036, 32'h5566_7788, 4'hF, rdy_at, we_low, be_b0, be_b1);
    chk("t4_rdata_kept", read_data, 32'hCAFE_BEEF);
    chk("t4_mem6", bus_mem[6], 16'h7788);

    run_reset_read(32'd1028);
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, 4'h0, rdy_at, we_low, be_b0, be_b1);
    chk("t5_rdata", read_data, 32'hCAFE_BEEF);

    for (int t = 0; t < 40; t++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'($urandom_range(1, 64)) * 32'd4;
      else a = 32'd1024 + 32'($urandom_range(0, 511)) * 32'd4 + 32'($urandom_range(0, 3));
      run_access(op != 1, op != 0, a, $urandom, 4'($urandom), rdy_at, we_low, be_b0, be_b1);
      chk("rnd_latency", rdy_at, 7);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_ready", ready, 1);
        chk("gap_ce_n", ce_n, 1);
        @(posedge clk); #1;
      end
    end

    exp6[0] = 16'h4444; exp6[1] = 16'h3333; exp6[2] = 16'h2222; exp6[3] = 16'h1111;
    wd_w = 64'h1111_2222_3333_4444; addr_w = 32'd1032; be_w = 8'hFF; wr_w = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) chk("w64_c0_ready", ready_w, 0);
      else if (k <= 4) begin
        chk("w64_ready", ready_w, 0);
        chk("w64_ce_n", ce_n_w, 0);
        chk("w64_we_n", we_n_w, 0);
        chk("w64_oe_n", oe_n_w, 1);
        chk("w64_be_n", be_n_w, 2'b00);
        chk("w64_addr", sram_addr_w, 18'd4 + 18'(k - 1));
        chk("w64_dq", dq_w, exp6[k-1]);
      end else if (k == 5) begin
        chk("w64_done_ready", ready_w, 1);
        chk("w64_done_ce_n", ce_n_w, 1);
      end else begin
        chk("w64_norepeat_ready", ready_w, 1);
        chk("w64_norepeat_ce_n", ce_n_w, 1);
      end
      @(posedge clk); #1;
      if (k == 5) wr_w = 1'b0;
    end
    chk("w64_rdata", rdata_w, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_word_ctrl.md
Name: sram_word_ctrl

Overview:
Parametrised SRAM access controller that sits between the MEM stage and the external SRAM. It is the successor to the fixed 32-bit-over-16-bit SRAM path, generalised in word width, SRAM data width, wait states and address base, and it adds per-byte write enables. One WORD_W request is split into BEATS = WORD_W/SRAM_DW sequential SRAM beats. The pipeline is frozen through `ready` until the access completes.

Parameters:
- WORD_W, 32, pipeline data word width; must be a multiple of SRAM_DW.
- SRAM_DW, 16, SRAM data bus width; must be a multiple of 8.
- SRAM_AW, 18, SRAM address width.
- ADDR_W, 32, pipeline byte-address width.
- WAIT_CYCLES, 3, clock cycles per SRAM beat; must be >= 1.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request; held stable while ready=0.
- rd_en  in  1  read request; held stable while ready=0.
- address  in  ADDR_W  byte address.
- write_data  in  WORD_W  store data.
- byte_en  in  WORD_W/8  byte write mask; bit i covers write_data[8i+7:8i].
- read_data  out  WORD_W  load result.
- ready  out  1  0 = freeze the pipeline.
- SRAM_DQ  inout  SRAM_DW  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM word address.
- SRAM_BE_N  out  SRAM_DW/8  active-low byte lanes.
- SRAM_WE_N  out  1  active-low write strobe.
- SRAM_CE_N  out  1  active-low chip enable.
- SRAM_OE_N  out  1  active-low output enable.

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst, sampled on the rising edge of clk).
- FSM states: IDLE, ACCESS, DONE. Registers: beat counter, wait counter, latched op/address/data/mask.
- IDLE transitions:
  - If (rd_en|wr_en), latch the request and go to ACCESS.
  - If both rd_en and wr_en are set, the op is a write.
- ACCESS:
  - The wait counter runs 0..WAIT_CYCLES-1.
  - On the last wait cycle the beat counter increments.
  - After beat BEATS-1 completes, go to DONE.
- DONE: go to IDLE unconditionally. The held request is not re-issued.
- ready is combinational:
  - IDLE: ready = ~(rd_en|wr_en).
  - ACCESS: ready = 0.
  - DONE: ready = 1.
- Latency: request cycle c0, ACCESS for c1..c(BEATS*WAIT_CYCLES), DONE (ready=1) at c(BEATS*WAIT_CYCLES+1). With defaults this is c7. Latency is fixed; beats are never skipped, even when their mask is all zero.
- Address mapping:
  - word_idx = (address - BASE_ADDR) >> log2(WORD_W/8); low byte-offset bits are ignored.
  - SRAM_ADDR = word_idx*BEATS + beat, truncated to SRAM_AW (wraps modulo 2^SRAM_AW).
  - Addresses below BASE_ADDR wrap the same way; there is no error flag.
- Beat order: beat 0 carries the least-significant slice, [SRAM_DW-1:0].
- Write beat:
  - SRAM_CE_N=0, SRAM_OE_N=1.
  - SRAM_DQ is driven with the current slice of the latched write data.
  - SRAM_BE_N = ~latched byte_en slice.
  - SRAM_WE_N=0 on every wait cycle except the last, where it is 1 so the data hold time is met. When WAIT_CYCLES=1, WE_N=0 for that single cycle.
- Read beat:
  - SRAM_CE_N=0, SRAM_OE_N=0, SRAM_WE_N=1, SRAM_BE_N=all 0.
  - SRAM_DQ is high-Z.
  - SRAM_DQ is sampled on the last wait cycle into the read_data slice for that beat.
- read_data:
  - The full word is valid from DONE onward.
  - It holds until the next read overwrites it; writes do not modify it.
  - During a read, partially updated slices are visible before DONE.
- IDLE and DONE drive CE_N=1, WE_N=1, OE_N=1, BE_N=all 1, DQ high-Z.
- Reset values: state=IDLE, counters=0, read_data=0, SRAM strobes deasserted, DQ high-Z. ready follows the IDLE rule, so ready=1 with no request pending.
- Reset mid-access:
  - The access is aborted and the FSM goes to IDLE at the next edge.
  - A partial write may have reached SRAM.
  - read_data is cleared to 0.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - functions for BEATS, the byte-offset shift and the counter widths (clog2 of WAIT_CYCLES and BEATS).
- One sub-module, sram_beat_timer, contains the wait and beat counters. It outputs beat_idx, last_wait and last_beat.

Test Plan:
1. Defaults, wr_en=1, address=1024, write_data=0xA5A5_1234, byte_en=4'hF, held:
   - ready=0 for c0..c6, ready=1 at c7.
   - SRAM writes 0x1234 to address 0, then 0xA5A5 to address 1.
   - WE_N low on 2 of every 3 cycles per beat.
2. rd_en=1 at address=1028, with a bus model returning 0xBEEF at SRAM address 2 and 0xCAFE at address 3:
   - read_data=0xCAFE_BEEF and ready=1 at c7.
   - OE_N=0 and WE_N=1 throughout ACCESS.
3. Write with byte_en=4'b0110 at address=1032:
   - beat 0 BE_N=2'b01, beat 1 BE_N=2'b10.
   - Latency stays 7.
4. rd_en=1 and wr_en=1 together:
   - Performs a write; read_data is unchanged from its prior value.
5. rst asserted at c3 of a read:
   - Next cycle: state IDLE, all strobes high, DQ high-Z, read_data=0.
   - A new read completes normally.
6. Parameters WORD_W=64, SRAM_DW=16, WAIT_CYCLES=1, write at BASE_ADDR+8:
   - 4 beats to SRAM addresses 4..7.
   - ready=1 at c5.
   - A request held through DONE is not repeated.
